// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BHT of 2-bit saturating counters
// plus a tagged BTB. Lookup is combinational on fetch_pc; training comes from
// the execute-stage branch resolution, which also raises the redirect request.
module branch_predictor #(
   parameter int IDX_W = 6,
   parameter int TAG_W = 30 - IDX_W
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] fetch_pc,
   output logic        pred_taken,
   output logic [31:0] pred_target,
   input  logic        ex_valid,
   input  logic [31:0] ex_pc,
   input  logic        ex_branch_taken,
   input  logic [31:0] ex_target,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pred_target,
   output logic        mispredict,
   output logic [31:0] redirect_pc,
   output logic [31:0] branch_cnt,
   output logic [31:0] mispredict_cnt
);

   localparam int N = 1 << IDX_W;

   // Table state, packed per entry so the whole table can be copied in one go.
   logic [N-1:0]             valid_q,  valid_d;
   logic [N-1:0][TAG_W-1:0]  tag_q,    tag_d;
   logic [N-1:0][31:0]       target_q, target_d;
   logic [N-1:0][1:0]        ctr_q,    ctr_d;
   logic [31:0]              branch_cnt_q, branch_cnt_d;
   logic [31:0]              mispredict_cnt_q, mispredict_cnt_d;

   logic [IDX_W-1:0] fetch_idx, ex_idx;
   logic [TAG_W-1:0] fetch_tag, ex_tag;
   logic             fetch_hit, ex_hit, upd;

   assign fetch_idx = fetch_pc[IDX_W+1:2];
   assign fetch_tag = fetch_pc[31:IDX_W+2];
   assign ex_idx    = ex_pc[IDX_W+1:2];
   assign ex_tag    = ex_pc[31:IDX_W+2];

   // A resolution arriving in a reset cycle is dropped entirely.
   assign upd = ex_valid && !rst;

   // Lookup from registered state only: same-cycle updates are not bypassed.
   always_comb begin
      fetch_hit   = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
      pred_taken  = fetch_hit && ctr_q[fetch_idx][1];
      pred_target = pred_taken ? target_q[fetch_idx] : fetch_pc + 32'd4;
   end

   // Mispredict detection and the corrected next PC for the fetch mux.
   always_comb begin
      mispredict  = upd && ((ex_branch_taken != ex_pred_taken) ||
                            (ex_branch_taken && (ex_target != ex_pred_target)));
      redirect_pc = ex_branch_taken ? ex_target : ex_pc + 32'd4;
   end

   // Next table contents and counters for this cycle's resolution.
   always_comb begin
      valid_d          = valid_q;
      tag_d            = tag_q;
      target_d         = target_q;
      ctr_d            = ctr_q;
      branch_cnt_d     = branch_cnt_q;
      mispredict_cnt_d = mispredict_cnt_q;
      ex_hit           = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
      if (upd) begin
         branch_cnt_d = branch_cnt_q + 32'd1;
         if (mispredict) begin
            mispredict_cnt_d = mispredict_cnt_q + 32'd1;
         end
         if (ex_hit) begin
            if (ex_branch_taken) begin
               if (ctr_q[ex_idx] != 2'b11) begin
                  ctr_d[ex_idx] = ctr_q[ex_idx] + 2'd1;
               end
               target_d[ex_idx] = ex_target;
            end else if (ctr_q[ex_idx] != 2'b00) begin
               ctr_d[ex_idx] = ctr_q[ex_idx] - 2'd1;
            end
         end else if (ex_branch_taken) begin
            // Allocate (or evict an alias) as weakly taken.
            valid_d[ex_idx]  = 1'b1;
            tag_d[ex_idx]    = ex_tag;
            target_d[ex_idx] = ex_target;
            ctr_d[ex_idx]    = 2'b10;
         end
      end
   end

   // State registers; tag/target contents need no reset since valid gates them.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q          <= '0;
         ctr_q            <= {N{2'b01}};
         branch_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
      end else begin
         valid_q          <= valid_d;
         ctr_q            <= ctr_d;
         branch_cnt_q     <= branch_cnt_d;
         mispredict_cnt_q <= mispredict_cnt_d;
      end
      tag_q    <= tag_d;
      target_q <= target_d;
   end

   assign branch_cnt     = branch_cnt_q;
   assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: inputs change on the falling edge,
// combinational outputs are checked 1 ns later, state advances on the rising edge.
`timescale 1ns/1ps
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] fetch_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        ex_valid;
   logic [31:0] ex_pc;
   logic        ex_branch_taken;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [31:0] ex_pred_target;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic [31:0] branch_cnt;
   logic [31:0] mispredict_cnt;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   branch_predictor #(.IDX_W(6)) dut (
      .clk(clk), .rst(rst), .fetch_pc(fetch_pc),
      .pred_taken(pred_taken), .pred_target(pred_target),
      .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_branch_taken(ex_branch_taken),
      .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
      .ex_pred_target(ex_pred_target), .mispredict(mispredict),
      .redirect_pc(redirect_pc), .branch_cnt(branch_cnt),
      .mispredict_cnt(mispredict_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one cycle and return to the falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                          input logic ptk, input logic [31:0] ptgt);
      ex_valid        = 1'b1;
      ex_pc           = pc;
      ex_branch_taken = tk;
      ex_target       = tgt;
      ex_pred_taken   = ptk;
      ex_pred_target  = ptgt;
   endtask

   task automatic idle();
      ex_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; fetch_pc = 32'h100;
      resolve(32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
      #1;
      chk("mp_low_in_reset", mispredict, 32'd0);
      @(negedge clk);
      tick();
      rst = 1'b0; idle(); #1;
      chk("rst_pred_taken", pred_taken, 32'd0);
      chk("rst_pred_target", pred_target, 32'h104);
      chk("rst_branch_cnt", branch_cnt, 32'd0);
      chk("rst_mp_cnt", mispredict_cnt, 32'd0);

      // Cold miss, taken: allocate weakly taken.
      @(negedge clk);
      resolve(32'h100, 1'b1, 32'h80, 1'b0, 32'h0); #1;
      chk("cold_mp", mispredict, 32'd1);
      chk("cold_redirect", redirect_pc, 32'h80);
      chk("cold_no_bypass", pred_taken, 32'd0);
      tick(); idle(); #1;
      chk("cold_pred_taken", pred_taken, 32'd1);
      chk("cold_pred_target", pred_target, 32'h80);
      chk("cold_mp_cnt", mispredict_cnt, 32'd1);
      chk("cold_br_cnt", branch_cnt, 32'd1);

      // Three correct taken resolutions saturate the counter at 11.
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         resolve(32'h100, 1'b1, 32'h80, 1'b1, 32'h80); #1;
         chk("sat_no_mp", mispredict, 32'd0);
         tick();
      end
      // Not taken once: 11 -> 10, still predicts taken.
      resolve(32'h100, 1'b0, 32'h80, 1'b1, 32'h80); #1;
      chk("nt1_mp", mispredict, 32'd1);
      chk("nt1_redirect", redirect_pc, 32'h104);
      tick(); idle(); #1;
      chk("nt1_pred_taken", pred_taken, 32'd1);
      chk("nt1_cnts", {mispredict_cnt[15:0], branch_cnt[15:0]}, {16'd2, 16'd5});
      // Not taken again: 10 -> 01, predicts not taken.
      @(negedge clk);
      resolve(32'h100, 1'b0, 32'h80, 1'b1, 32'h80);
      tick(); idle(); #1;
      chk("nt2_pred_taken", pred_taken, 32'd0);
      chk("nt2_pred_target", pred_target, 32'h104);
      chk("nt2_cnts", {mispredict_cnt[15:0], branch_cnt[15:0]}, {16'd3, 16'd6});

      // Hit taken from 01 -> 10, then a wrong target gets corrected.
      @(negedge clk);
      resolve(32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
      tick();
      resolve(32'h100, 1'b1, 32'h90, 1'b1, 32'h80); #1;
      chk("tgt_mp", mispredict, 32'd1);
      chk("tgt_redirect", redirect_pc, 32'h90);
      tick(); idle(); #1;
      chk("tgt_pred_taken", pred_taken, 32'd1);
      chk("tgt_pred_target", pred_target, 32'h90);
      chk("tgt_cnts", {mispredict_cnt[15:0], branch_cnt[15:0]}, {16'd5, 16'd8});

      // Alias: 0x200 shares the index of 0x100 with a different tag.
      @(negedge clk);
      fetch_pc = 32'h200; #1;
      chk("alias_miss", pred_taken, 32'd0);
      chk("alias_miss_tgt", pred_target, 32'h204);
      @(negedge clk);
      resolve(32'h200, 1'b1, 32'h300, 1'b0, 32'h0);
      tick(); idle(); #1;
      chk("alias_hit", pred_taken, 32'd1);
      chk("alias_hit_tgt", pred_target, 32'h300);
      fetch_pc = 32'h100; #1;
      chk("alias_evicted", pred_taken, 32'd0);

      // Miss and not taken leaves the table alone.
      @(negedge clk);
      resolve(32'h304, 1'b0, 32'h400, 1'b0, 32'h0); #1;
      chk("mnt_no_mp", mispredict, 32'd0);
      tick(); idle(); fetch_pc = 32'h304; #1;
      chk("mnt_still_miss", pred_taken, 32'd0);
      chk("mnt_cnts", {mispredict_cnt[15:0], branch_cnt[15:0]}, {16'd6, 16'd10});

      // Fall-through wraps around the top of the address space.
      fetch_pc = 32'hFFFF_FFFC; #1;
      chk("wrap_target", pred_target, 32'h0);

      // Reset arriving with a taken resolution in the same cycle.
      @(negedge clk);
      rst = 1'b1; fetch_pc = 32'h200;
      resolve(32'h200, 1'b1, 32'h500, 1'b0, 32'h0); #1;
      chk("midrst_no_mp", mispredict, 32'd0);
      tick(); rst = 1'b0; idle(); #1;
      chk("midrst_miss", pred_taken, 32'd0);
      chk("midrst_target", pred_target, 32'h204);
      chk("midrst_br_cnt", branch_cnt, 32'd0);
      chk("midrst_mp_cnt", mispredict_cnt, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
